cronometro_regressivo: RTL and testbench
========================================

Name: cronometro_regressivo

Overview:
- Countdown irrigation timer. Loads a preset duration in minutes, decrements MM:SS once per `umSegundo` tick and holds the valve open while running.
- Sits beside `divisorFrequencia`. Its BCD digit outputs feed the existing multiplexed 7-segment display path in place of the up-counting chronometer.
- Pauses automatically when the water reservoir reports empty.
- Raises a one-cycle completion pulse plus a sticky completion flag.

Parameters:
- MAX_MINUTOS, 59, upper clamp for the preset; must be ≤ 99.
- NIVEL_MINIMO, 1, lowest `nivelDagua` value treated as "water available".

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- umSegundo  input  1  one-clock-wide 1 Hz enable pulse from `divisorFrequencia`
- iniciar  input  1  start request, level-sampled
- abortar  input  1  abort request, level-sampled
- presetMinutos  input  7  binary duration in minutes
- nivelDagua  input  3  reservoir level; values below NIVEL_MINIMO inhibit
- dezenaMinuto  output  4  BCD tens of minutes
- unidadeMinuto  output  4  BCD units of minutes
- dezenaSegundos  output  4  BCD tens of seconds
- unidadeSegundos  output  4  BCD units of seconds
- valvula  output  1  irrigation valve drive, 1 = open
- emPausa  output  1  high in PAUSADO
- concluidoPulso  output  1  one-cycle pulse when 00:00 is reached
- concluido  output  1  sticky completion flag
- apagarDisplay  output  1  display blank request; see Optional Feature

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State = OCIOSO, all digits 0.
  - valvula, emPausa, concluidoPulso, concluido and apagarDisplay all 0.
- States: OCIOSO, CONTANDO, PAUSADO.
- Registered outputs, and `inibe = (nivelDagua < NIVEL_MINIMO)`.
- Priority each cycle: abortar > state transition / load > umSegundo decrement.
- abortar == 1 in any state:
  - Next state OCIOSO, digits cleared to 00:00, valvula 0.
  - concluido unchanged; concluidoPulso 0.
- OCIOSO, iniciar == 1:
  - Load `min(presetMinutos, MAX_MINUTOS)` into the minute digits, converted binary→BCD; seconds = 00.
  - concluido cleared.
  - Next state: PAUSADO if inibe, else CONTANDO.
  - A umSegundo arriving in the load cycle is ignored; the first decrement happens on the next tick.
- OCIOSO, iniciar == 1 with clamped preset == 0:
  - Stay OCIOSO, digits 00:00.
  - concluidoPulso = 1 for one cycle and concluido set.
- CONTANDO:
  - valvula = 1.
  - On umSegundo, decrement in BCD:
    - unidadeSegundos 0 → 9 with a borrow into dezenaSegundos.
    - dezenaSegundos 0 → 5 with a borrow into unidadeMinuto.
    - unidadeMinuto 0 → 9 with a borrow into dezenaMinuto.
  - A decrement that produces 00:00 does all of the following in the same edge:
    - Next state OCIOSO.
    - valvula 0.
    - concluidoPulso 1 for exactly one cycle.
    - concluido set.
  - inibe == 1 → next state PAUSADO and valvula 0, even if umSegundo is active in that cycle; no decrement.
  - iniciar is ignored while counting; no restart.
- PAUSADO:
  - Digits hold, valvula 0, emPausa 1.
  - inibe == 0 → CONTANDO on the next edge; the count resumes at the next tick.
  - iniciar is ignored.
- Digits are always valid BCD: seconds tens 0–5, all others 0–9.
- No wrap below 00:00.
- presetMinutos values above MAX_MINUTOS are clamped and never flagged as an error.

Optional Feature:
- Macro: PAUSA_PISCA_EN.
- Defined:
  - In PAUSADO, apagarDisplay toggles on every umSegundo (0.5 Hz blink), starting at 1 on the first tick after entering PAUSADO.
  - It is forced to 0 on leaving PAUSADO, on abortar and on reset.
- Undefined:
  - apagarDisplay is constant 0.
  - No toggle register is synthesized.

Test Plan:
- Reset with reset = 0 for 2 cycles → all outputs 0, state OCIOSO; an umSegundo pulse has no effect.
- presetMinutos = 2, iniciar, no inhibit:
  - Digits 02:00 and valvula = 1.
  - After 1 tick → 01:59; after 60 ticks → 01:00.
  - After 120 ticks → 00:00, concluidoPulso high exactly 1 cycle, concluido = 1, valvula = 0.
- presetMinutos = 100 → loads 59:00 (clamp); presetMinutos = 0 → immediate concluidoPulso, valvula never asserts.
- Running at 01:30, nivelDagua = 0 with a simultaneous tick:
  - PAUSADO, digits stay 01:30, valvula 0, emPausa 1.
  - nivelDagua = 4 → CONTANDO; the next tick gives 01:29.
- abortar asserted at 00:45 in the same cycle as a tick → 00:00, OCIOSO, valvula 0, no concluidoPulso; concluido keeps its prior value.
- PAUSA_PISCA_EN defined, paused for 4 ticks → apagarDisplay sequence 1,0,1,0; on resume apagarDisplay = 0. Build without the macro → apagarDisplay constant 0.

Source files
------------

// File: rtl/cronometro_regressivo.sv
// cronometro_regressivo: countdown irrigation timer with a BCD MM:SS display.
// Loads a preset in minutes, counts down once per umSegundo tick and keeps
// the valve open while running. Pauses while the reservoir reads empty.
//
// Ports:
//   clock, reset (sync, active-low)
//   umSegundo      1 Hz one-cycle enable
//   iniciar        start request (level)
//   abortar        abort request (level), highest priority
//   presetMinutos  binary minutes, clamped to MAX_MINUTOS
//   nivelDagua     reservoir level, < NIVEL_MINIMO inhibits
//   dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos  BCD digits
//   valvula        valve drive, 1 = open
//   emPausa        high while paused
//   concluidoPulso one-cycle pulse on reaching 00:00
//   concluido      sticky completion flag
//   apagarDisplay  display blank request (blinks while paused)
//
// Optional: define PAUSA_PISCA_EN to enable the blink of apagarDisplay
// while paused; otherwise apagarDisplay is tied to 0.
module cronometro_regressivo #(
    parameter int MAX_MINUTOS  = 59,
    parameter int NIVEL_MINIMO = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       umSegundo,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [6:0] presetMinutos,
    input  logic [2:0] nivelDagua,
    output logic [3:0] dezenaMinuto,
    output logic [3:0] unidadeMinuto,
    output logic [3:0] dezenaSegundos,
    output logic [3:0] unidadeSegundos,
    output logic       valvula,
    output logic       emPausa,
    output logic       concluidoPulso,
    output logic       concluido,
    output logic       apagarDisplay
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] dm_q, dm_d;
    logic [3:0] um_q, um_d;
    logic [3:0] ds_q, ds_d;
    logic [3:0] us_q, us_d;
    logic       valvula_q, valvula_d;
    logic       pulso_q, pulso_d;
    logic       concluido_q, concluido_d;

    logic       inibe;
    logic [6:0] minutos_lim;
    logic [3:0] carga_dm, carga_um;
    logic [3:0] dec_dm, dec_um, dec_ds, dec_us;
    logic       b0, b1, b2;
    logic       zero_agora, zero_dec;

    assign inibe = (nivelDagua < 3'(NIVEL_MINIMO));

    assign minutos_lim = (presetMinutos > 7'(MAX_MINUTOS))
                       ? 7'(MAX_MINUTOS) : presetMinutos;

    // Preset never exceeds 99, so a single divide/modulo gives two BCD digits.
    assign carga_dm = 4'(minutos_lim / 7'd10);
    assign carga_um = 4'(minutos_lim % 7'd10);

    // Cascaded BCD borrow: each digit borrows only when all lower digits are 0.
    assign b0     = (us_q == 4'd0);
    assign b1     = b0 && (ds_q == 4'd0);
    assign b2     = b1 && (um_q == 4'd0);
    assign dec_us = b0 ? 4'd9 : us_q - 4'd1;
    assign dec_ds = b0 ? ((ds_q == 4'd0) ? 4'd5 : ds_q - 4'd1) : ds_q;
    assign dec_um = b1 ? ((um_q == 4'd0) ? 4'd9 : um_q - 4'd1) : um_q;
    assign dec_dm = b2 ? dm_q - 4'd1 : dm_q;

    assign zero_agora = ({dm_q, um_q, ds_q, us_q} == 16'h0000);
    assign zero_dec   = ({dec_dm, dec_um, dec_ds, dec_us} == 16'h0000);

    always_comb begin
        estado_d    = estado_q;
        dm_d        = dm_q;
        um_d        = um_q;
        ds_d        = ds_q;
        us_d        = us_q;
        pulso_d     = 1'b0;
        concluido_d = concluido_q;

        if (abortar) begin
            estado_d = OCIOSO;
            dm_d     = 4'd0;
            um_d     = 4'd0;
            ds_d     = 4'd0;
            us_d     = 4'd0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        if (minutos_lim == 7'd0) begin
                            dm_d        = 4'd0;
                            um_d        = 4'd0;
                            ds_d        = 4'd0;
                            us_d        = 4'd0;
                            pulso_d     = 1'b1;
                            concluido_d = 1'b1;
                        end else begin
                            dm_d        = carga_dm;
                            um_d        = carga_um;
                            ds_d        = 4'd0;
                            us_d        = 4'd0;
                            concluido_d = 1'b0;
                            estado_d    = inibe ? PAUSADO : CONTANDO;
                        end
                    end
                end
                CONTANDO: begin
                    if (inibe) begin
                        estado_d = PAUSADO;
                    end else if (umSegundo) begin
                        // Never wrap: a tick at 00:00 just finishes.
                        if (zero_agora || zero_dec) begin
                            dm_d        = 4'd0;
                            um_d        = 4'd0;
                            ds_d        = 4'd0;
                            us_d        = 4'd0;
                            estado_d    = OCIOSO;
                            pulso_d     = 1'b1;
                            concluido_d = 1'b1;
                        end else begin
                            dm_d = dec_dm;
                            um_d = dec_um;
                            ds_d = dec_ds;
                            us_d = dec_us;
                        end
                    end
                end
                PAUSADO: begin
                    if (!inibe) begin
                        estado_d = CONTANDO;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end

        valvula_d = (estado_d == CONTANDO);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            dm_q        <= 4'd0;
            um_q        <= 4'd0;
            ds_q        <= 4'd0;
            us_q        <= 4'd0;
            valvula_q   <= 1'b0;
            pulso_q     <= 1'b0;
            concluido_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            dm_q        <= dm_d;
            um_q        <= um_d;
            ds_q        <= ds_d;
            us_q        <= us_d;
            valvula_q   <= valvula_d;
            pulso_q     <= pulso_d;
            concluido_q <= concluido_d;
        end
    end

`ifdef PAUSA_PISCA_EN
    logic pisca_q, pisca_d;

    // Cleared on entry, so the first tick spent paused turns the blank on.
    always_comb begin
        pisca_d = 1'b0;
        if (estado_q == PAUSADO && estado_d == PAUSADO) begin
            pisca_d = umSegundo ? ~pisca_q : pisca_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pisca_q <= 1'b0;
        end else begin
            pisca_q <= pisca_d;
        end
    end

    assign apagarDisplay = pisca_q;
`else
    assign apagarDisplay = 1'b0;
`endif

    assign dezenaMinuto    = dm_q;
    assign unidadeMinuto   = um_q;
    assign dezenaSegundos  = ds_q;
    assign unidadeSegundos = us_q;
    assign valvula         = valvula_q;
    assign emPausa         = (estado_q == PAUSADO);
    assign concluidoPulso  = pulso_q;
    assign concluido       = concluido_q;

endmodule

// File: tb/tb_cronometro_regressivo.sv
// tb_cronometro_regressivo: directed bench for the countdown timer.
// Inputs change 1 ns after each rising edge; outputs are read there too.
module tb_cronometro_regressivo;

    logic       clock = 1'b0;
    logic       reset;
    logic       umSegundo;
    logic       iniciar;
    logic       abortar;
    logic [6:0] presetMinutos;
    logic [2:0] nivelDagua;
    logic [3:0] dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos;
    logic       valvula, emPausa, concluidoPulso, concluido, apagarDisplay;
    logic [15:0] dig;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign dig = {dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos};

    cronometro_regressivo dut (
        .clock           (clock),
        .reset           (reset),
        .umSegundo       (umSegundo),
        .iniciar         (iniciar),
        .abortar         (abortar),
        .presetMinutos   (presetMinutos),
        .nivelDagua      (nivelDagua),
        .dezenaMinuto    (dezenaMinuto),
        .unidadeMinuto   (unidadeMinuto),
        .dezenaSegundos  (dezenaSegundos),
        .unidadeSegundos (unidadeSegundos),
        .valvula         (valvula),
        .emPausa         (emPausa),
        .concluidoPulso  (concluidoPulso),
        .concluido       (concluido),
        .apagarDisplay   (apagarDisplay)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One tick followed by one idle cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            umSegundo = 1'b1;
            step();
            umSegundo = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        umSegundo = 1'b1;
        iniciar = 1'b0;
        abortar = 1'b0;
        presetMinutos = 7'd0;
        nivelDagua = 3'd4;
        step();
        step();
        umSegundo = 1'b0;
        n_cmp++;
        if (dig !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_digits: got %h expected 0000", dig);
        end
        n_cmp++;
        if ({valvula, emPausa, concluidoPulso, concluido, apagarDisplay} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {valvula, emPausa, concluidoPulso, concluido, apagarDisplay});
        end
        reset = 1'b1;
        ticks(1);
        n_cmp++;
        if (dig !== 16'h0000 || valvula !== 1'b0) begin
            n_err++;
            $display("FAIL idle_tick: got %h/%b expected 0000/0", dig, valvula);
        end
    endtask

    task automatic test_contagem();
        presetMinutos = 7'd2;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (dig !== 16'h0200 || valvula !== 1'b1) begin
            n_err++;
            $display("FAIL load_2: got %h/%b expected 0200/1", dig, valvula);
        end
        ticks(1);
        n_cmp++;
        if (dig !== 16'h0159) begin
            n_err++;
            $display("FAIL tick_1: got %h expected 0159", dig);
        end
        ticks(59);
        n_cmp++;
        if (dig !== 16'h0100) begin
            n_err++;
            $display("FAIL tick_60: got %h expected 0100", dig);
        end
        ticks(59);
        n_cmp++;
        if (dig !== 16'h0001 || valvula !== 1'b1 || concluidoPulso !== 1'b0) begin
            n_err++;
            $display("FAIL tick_119: got %h/%b/%b expected 0001/1/0",
                     dig, valvula, concluidoPulso);
        end
        umSegundo = 1'b1;
        step();
        umSegundo = 1'b0;
        n_cmp++;
        if (dig !== 16'h0000 || valvula !== 1'b0 || concluidoPulso !== 1'b1
            || concluido !== 1'b1) begin
            n_err++;
            $display("FAIL done: got %h v=%b p=%b c=%b expected 0000 v=0 p=1 c=1",
                     dig, valvula, concluidoPulso, concluido);
        end
        step();
        n_cmp++;
        if (concluidoPulso !== 1'b0 || concluido !== 1'b1) begin
            n_err++;
            $display("FAIL pulse_width: got p=%b c=%b expected p=0 c=1",
                     concluidoPulso, concluido);
        end
        ticks(1);
        n_cmp++;
        if (dig !== 16'h0000 || valvula !== 1'b0) begin
            n_err++;
            $display("FAIL no_wrap: got %h/%b expected 0000/0", dig, valvula);
        end
    endtask

    task automatic test_clamp();
        presetMinutos = 7'd0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (dig !== 16'h0000 || concluidoPulso !== 1'b1 || concluido !== 1'b1
            || valvula !== 1'b0 || emPausa !== 1'b0) begin
            n_err++;
            $display("FAIL zero_preset: got %h p=%b c=%b v=%b e=%b expected 0000 1 1 0 0",
                     dig, concluidoPulso, concluido, valvula, emPausa);
        end
        step();
        n_cmp++;
        if (concluidoPulso !== 1'b0 || valvula !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after: got p=%b v=%b expected 0 0",
                     concluidoPulso, valvula);
        end
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        n_cmp++;
        if (concluido !== 1'b1) begin
            n_err++;
            $display("FAIL abort_keeps_done: got %b expected 1", concluido);
        end
        presetMinutos = 7'd100;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (dig !== 16'h5900 || valvula !== 1'b1 || concluido !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_100: got %h v=%b c=%b expected 5900 1 0",
                     dig, valvula, concluido);
        end
        presetMinutos = 7'd37;
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (dig !== 16'h3700) begin
            n_err++;
            $display("FAIL load_37: got %h expected 3700", dig);
        end
        abortar = 1'b1;
        step();
        abortar = 1'b0;
    endtask

    task automatic test_pausa();
        logic [3:0] exp_pisca;
        presetMinutos = 7'd2;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        ticks(30);
        n_cmp++;
        if (dig !== 16'h0130) begin
            n_err++;
            $display("FAIL at_0130: got %h expected 0130", dig);
        end
        nivelDagua = 3'd0;
        umSegundo = 1'b1;
        step();
        umSegundo = 1'b0;
        n_cmp++;
        if (dig !== 16'h0130 || valvula !== 1'b0 || emPausa !== 1'b1
            || apagarDisplay !== 1'b0) begin
            n_err++;
            $display("FAIL pause_enter: got %h v=%b e=%b a=%b expected 0130 0 1 0",
                     dig, valvula, emPausa, apagarDisplay);
        end
`ifdef PAUSA_PISCA_EN
        exp_pisca = 4'b1010;
`else
        exp_pisca = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            iniciar = 1'b1;
            umSegundo = 1'b1;
            step();
            umSegundo = 1'b0;
            iniciar = 1'b0;
            n_cmp++;
            if (apagarDisplay !== exp_pisca[3-i] || dig !== 16'h0130
                || emPausa !== 1'b1) begin
                n_err++;
                $display("FAIL blink_%0d: got a=%b %h e=%b expected a=%b 0130 e=1",
                         i, apagarDisplay, dig, emPausa, exp_pisca[3-i]);
            end
            step();
        end
        nivelDagua = 3'd4;
        step();
        n_cmp++;
        if (dig !== 16'h0130 || valvula !== 1'b1 || emPausa !== 1'b0
            || apagarDisplay !== 1'b0) begin
            n_err++;
            $display("FAIL resume: got %h v=%b e=%b a=%b expected 0130 1 0 0",
                     dig, valvula, emPausa, apagarDisplay);
        end
        ticks(1);
        n_cmp++;
        if (dig !== 16'h0129) begin
            n_err++;
            $display("FAIL resume_tick: got %h expected 0129", dig);
        end
    endtask

    task automatic test_abortar();
        ticks(44);
        n_cmp++;
        if (dig !== 16'h0045) begin
            n_err++;
            $display("FAIL at_0045: got %h expected 0045", dig);
        end
        abortar = 1'b1;
        umSegundo = 1'b1;
        step();
        abortar = 1'b0;
        umSegundo = 1'b0;
        n_cmp++;
        if (dig !== 16'h0000 || valvula !== 1'b0 || concluidoPulso !== 1'b0
            || concluido !== 1'b0 || emPausa !== 1'b0) begin
            n_err++;
            $display("FAIL abort: got %h v=%b p=%b c=%b e=%b expected 0000 0 0 0 0",
                     dig, valvula, concluidoPulso, concluido, emPausa);
        end
        ticks(2);
        n_cmp++;
        if (dig !== 16'h0000 || valvula !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got %h/%b expected 0000/0", dig, valvula);
        end
    endtask

    task automatic test_back_to_back();
        presetMinutos = 7'd3;
        iniciar = 1'b1;
        step();
        presetMinutos = 7'd5;
        umSegundo = 1'b1;
        step();
        umSegundo = 1'b0;
        step();
        iniciar = 1'b0;
        n_cmp++;
        if (dig !== 16'h0259 || valvula !== 1'b1) begin
            n_err++;
            $display("FAIL no_restart: got %h/%b expected 0259/1", dig, valvula);
        end
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        nivelDagua = 3'd0;
        presetMinutos = 7'd10;
        iniciar = 1'b1;
        umSegundo = 1'b1;
        step();
        iniciar = 1'b0;
        umSegundo = 1'b0;
        n_cmp++;
        if (dig !== 16'h1000 || emPausa !== 1'b1 || valvula !== 1'b0) begin
            n_err++;
            $display("FAIL start_inhibited: got %h e=%b v=%b expected 1000 1 0",
                     dig, emPausa, valvula);
        end
        nivelDagua = 3'd1;
        step();
        n_cmp++;
        if (valvula !== 1'b1 || emPausa !== 1'b0) begin
            n_err++;
            $display("FAIL level_min: got v=%b e=%b expected 1 0", valvula, emPausa);
        end
        ticks(1);
        n_cmp++;
        if (dig !== 16'h0959) begin
            n_err++;
            $display("FAIL borrow_tens: got %h expected 0959", dig);
        end
    endtask

    initial begin
        test_reset();
        test_contagem();
        test_clamp();
        test_pausa();
        test_abortar();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
